// File: rtl/id_ex_reg_pkg.sv
// rtl/id_ex_reg_pkg.sv - shared widths, op-class codes and constants for the ID->EX register
package id_ex_reg_pkg;

    localparam int OP_HIGH_W = 3;
    localparam int OP_LOW_W  = 4;
    localparam int WORD_W    = 32;
    localparam int REG_AW    = 5;

    localparam logic [OP_HIGH_W-1:0] EX_HIGH_NOP   = 3'd0;
    localparam logic [OP_HIGH_W-1:0] EX_HIGH_LOGIC = 3'd1;
    localparam logic [OP_HIGH_W-1:0] EX_HIGH_ARITH = 3'd2;
    localparam logic [OP_HIGH_W-1:0] EX_HIGH_SHIFT = 3'd3;
    localparam logic [OP_HIGH_W-1:0] EX_HIGH_MOVE  = 3'd4;
    localparam logic [OP_HIGH_W-1:0] EX_HIGH_JUMP  = 3'd5;

    localparam logic [OP_LOW_W-1:0] EX_LOGIC_AND = 4'd0;
    localparam logic [OP_LOW_W-1:0] EX_LOGIC_OR  = 4'd1;
    localparam logic [OP_LOW_W-1:0] EX_LOGIC_XOR = 4'd2;
    localparam logic [OP_LOW_W-1:0] EX_LOGIC_NOR = 4'd3;

    localparam logic [WORD_W-1:0] ZERO_WORD = '0;

    // Unit enable: a bubble never enables a unit, whatever its class field holds.
    function automatic logic unit_sel(input logic valid,
                                      input logic [OP_HIGH_W-1:0] op_high,
                                      input logic [OP_HIGH_W-1:0] cls);
        return valid && (op_high == cls);
    endfunction

endpackage

// File: rtl/id_ex_reg_pipe_field_reg.sv
// rtl/id_ex_reg_pipe_field_reg.sv - one pipeline field group with flush/bubble/hold/load control
module pipe_field_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         bubble,
    input  logic         hold,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // All-zero is the bubble encoding (NOP class, no writeback, not valid).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (flush || bubble) begin
            q <= '0;
        end else if (hold) begin
            q <= q;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID->EX pipeline register with stall-hold, bubble, flush and delay-slot tracking
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int OP_HIGH_W_P = OP_HIGH_W,
    parameter int OP_LOW_W_P  = OP_LOW_W,
    parameter int WORD_W_P    = WORD_W,
    parameter int REG_AW_P    = REG_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   stallId,
    input  logic                   stallEx,
    input  logic [OP_HIGH_W_P-1:0] idOpHigh,
    input  logic [OP_LOW_W_P-1:0]  idOpLow,
    input  logic [WORD_W_P-1:0]    idSrcLeft,
    input  logic [WORD_W_P-1:0]    idSrcRight,
    input  logic                   idWriteEnable,
    input  logic [REG_AW_P-1:0]    idWriteAddr,
    input  logic [WORD_W_P-1:0]    idLinkAddr,
    input  logic                   idInDelaySlot,
    input  logic                   idNextInDelaySlot,
    output logic                   exValid,
    output logic [OP_HIGH_W_P-1:0] exOpHigh,
    output logic [OP_LOW_W_P-1:0]  exOpLow,
    output logic [WORD_W_P-1:0]    exSrcLeft,
    output logic [WORD_W_P-1:0]    exSrcRight,
    output logic                   exWriteEnable,
    output logic [REG_AW_P-1:0]    exWriteAddr,
    output logic [WORD_W_P-1:0]    exLinkAddr,
    output logic                   exInDelaySlot,
    output logic                   exLogicEnable,
    output logic                   exArithEnable,
    output logic                   exShiftEnable,
    output logic                   idIsInDelaySlot
);

    localparam int CTRL_W = 1 + OP_HIGH_W_P + OP_LOW_W_P + 1 + REG_AW_P + 1;
    localparam int DATA_W = 3 * WORD_W_P;

    logic bubble;
    logic hold;
    logic load;

    // EX stalled holds everything; stallEx without stallId is illegal but also holds.
    assign bubble = stallId && !stallEx;
    assign hold   = stallEx;
    assign load   = !stallId && !stallEx;

    pipe_field_reg #(.W(CTRL_W)) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .bubble (bubble),
        .hold   (hold),
        .load   (load),
        .d      ({1'b1, idOpHigh, idOpLow, idWriteEnable, idWriteAddr, idInDelaySlot}),
        .q      ({exValid, exOpHigh, exOpLow, exWriteEnable, exWriteAddr, exInDelaySlot})
    );

    pipe_field_reg #(.W(DATA_W)) u_data (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .bubble (bubble),
        .hold   (hold),
        .load   (load),
        .d      ({idSrcLeft, idSrcRight, idLinkAddr}),
        .q      ({exSrcLeft, exSrcRight, exLinkAddr})
    );

    // A bubble keeps the flag: the branch it follows has not left ID's view yet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idIsInDelaySlot <= 1'b0;
        end else if (flush) begin
            idIsInDelaySlot <= 1'b0;
        end else if (load) begin
            idIsInDelaySlot <= idNextInDelaySlot;
        end
    end

    assign exLogicEnable = unit_sel(exValid, OP_HIGH_W'(exOpHigh), EX_HIGH_LOGIC);
    assign exArithEnable = unit_sel(exValid, OP_HIGH_W'(exOpHigh), EX_HIGH_ARITH);
    assign exShiftEnable = unit_sel(exValid, OP_HIGH_W'(exOpHigh), EX_HIGH_SHIFT);

    illegal_stall_combo: assert property (@(posedge clk) disable iff (!rst || flush)
                                          !(stallEx && !stallId));

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - randomized and directed self-checking bench for id_ex_reg
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, stallId, stallEx;
    logic [2:0]  idOpHigh;
    logic [3:0]  idOpLow;
    logic [31:0] idSrcLeft, idSrcRight, idLinkAddr;
    logic        idWriteEnable;
    logic [4:0]  idWriteAddr;
    logic        idInDelaySlot, idNextInDelaySlot;

    logic        exValid;
    logic [2:0]  exOpHigh;
    logic [3:0]  exOpLow;
    logic [31:0] exSrcLeft, exSrcRight, exLinkAddr;
    logic        exWriteEnable;
    logic [4:0]  exWriteAddr;
    logic        exInDelaySlot;
    logic        exLogicEnable, exArithEnable, exShiftEnable;
    logic        idIsInDelaySlot;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        valid;
        logic [2:0]  oph;
        logic [3:0]  opl;
        logic [31:0] l;
        logic [31:0] r;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] link;
        logic        ds;
    } ex_t;

    ex_t  m;
    logic m_ids;
    ex_t  snap;

    id_ex_reg dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .stallId           (stallId),
        .stallEx           (stallEx),
        .idOpHigh          (idOpHigh),
        .idOpLow           (idOpLow),
        .idSrcLeft         (idSrcLeft),
        .idSrcRight        (idSrcRight),
        .idWriteEnable     (idWriteEnable),
        .idWriteAddr       (idWriteAddr),
        .idLinkAddr        (idLinkAddr),
        .idInDelaySlot     (idInDelaySlot),
        .idNextInDelaySlot (idNextInDelaySlot),
        .exValid           (exValid),
        .exOpHigh          (exOpHigh),
        .exOpLow           (exOpLow),
        .exSrcLeft         (exSrcLeft),
        .exSrcRight        (exSrcRight),
        .exWriteEnable     (exWriteEnable),
        .exWriteAddr       (exWriteAddr),
        .exLinkAddr        (exLinkAddr),
        .exInDelaySlot     (exInDelaySlot),
        .exLogicEnable     (exLogicEnable),
        .exArithEnable     (exArithEnable),
        .exShiftEnable     (exShiftEnable),
        .idIsInDelaySlot   (idIsInDelaySlot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(exValid), 32'(m.valid));
        chk({tag, ".oph"},   32'(exOpHigh), 32'(m.oph));
        chk({tag, ".opl"},   32'(exOpLow), 32'(m.opl));
        chk({tag, ".left"},  exSrcLeft, m.l);
        chk({tag, ".right"}, exSrcRight, m.r);
        chk({tag, ".we"},    32'(exWriteEnable), 32'(m.we));
        chk({tag, ".wa"},    32'(exWriteAddr), 32'(m.wa));
        chk({tag, ".link"},  exLinkAddr, m.link);
        chk({tag, ".ds"},    32'(exInDelaySlot), 32'(m.ds));
        chk({tag, ".logic"}, 32'(exLogicEnable), 32'(m.valid && m.oph == 3'd1));
        chk({tag, ".arith"}, 32'(exArithEnable), 32'(m.valid && m.oph == 3'd2));
        chk({tag, ".shift"}, 32'(exShiftEnable), 32'(m.valid && m.oph == 3'd3));
        chk({tag, ".ids"},   32'(idIsInDelaySlot), 32'(m_ids));
        chk({tag, ".onehot"}, 32'($countones({exLogicEnable, exArithEnable, exShiftEnable}) <= 1), 32'd1);
    endtask

    // Reference behaviour of one rising edge, from the inputs present before it.
    task automatic model_edge();
        if (!rst) begin
            m = '0;
            m_ids = 1'b0;
        end else if (flush) begin
            m = '0;
            m_ids = 1'b0;
        end else if (stallId && !stallEx) begin
            m = '0;
        end else if (!stallId && !stallEx) begin
            m = '{valid: 1'b1, oph: idOpHigh, opl: idOpLow, l: idSrcLeft, r: idSrcRight,
                  we: idWriteEnable, wa: idWriteAddr, link: idLinkAddr, ds: idInDelaySlot};
            m_ids = idNextInDelaySlot;
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic randomize_id();
        idOpHigh          = 3'($urandom_range(0, 7));
        idOpLow           = 4'($urandom);
        idSrcLeft         = $urandom;
        idSrcRight        = $urandom;
        idWriteEnable     = 1'($urandom);
        idWriteAddr       = 5'($urandom);
        idLinkAddr        = $urandom;
        idInDelaySlot     = 1'($urandom);
        idNextInDelaySlot = 1'($urandom);
    endtask

    task automatic set_ctrl(input logic f, input logic si, input logic se);
        flush   = f;
        stallId = si;
        stallEx = se;
    endtask

    initial begin
        rst = 1'b0;
        set_ctrl(0, 0, 0);
        randomize_id();
        m = '0;
        m_ids = 1'b0;

        tick("reset");
        @(negedge clk);
        rst = 1'b1;
        set_ctrl(0, 1, 1);
        tick("post_reset_hold");

        // Directed load of a logic OR.
        @(negedge clk);
        set_ctrl(0, 0, 0);
        idOpHigh = 3'd1; idOpLow = 4'd1;
        idSrcLeft = 32'h0000F0F0; idSrcRight = 32'h00000F0F;
        idWriteEnable = 1'b1; idWriteAddr = 5'd5; idLinkAddr = 32'h0;
        idInDelaySlot = 1'b0; idNextInDelaySlot = 1'b0;
        tick("load");
        chk("load.logic_en", 32'(exLogicEnable), 32'd1);
        chk("load.left_k", exSrcLeft, 32'h0000F0F0);
        chk("load.right_k", exSrcRight, 32'h00000F0F);
        chk("load.wa_k", 32'(exWriteAddr), 32'd5);

        snap = m;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_ctrl(0, 1, 1);
            randomize_id();
            tick("hold");
            chk("hold.left_k", exSrcLeft, 32'h0000F0F0);
            chk("hold.ids_k", 32'(idIsInDelaySlot), 32'd0);
        end

        @(negedge clk);
        set_ctrl(0, 1, 0);
        idOpHigh = 3'd2; idWriteEnable = 1'b1; idNextInDelaySlot = 1'b0;
        tick("bubble");
        chk("bubble.valid_k", 32'(exValid), 32'd0);
        chk("bubble.we_k", 32'(exWriteEnable), 32'd0);
        @(negedge clk);
        set_ctrl(0, 0, 0);
        tick("after_bubble");
        chk("after_bubble.arith_k", 32'(exArithEnable), 32'd1);

        // Branch loaded, then flushed while both stages stall.
        @(negedge clk);
        idNextInDelaySlot = 1'b1;
        tick("branch");
        chk("branch.ids_k", 32'(idIsInDelaySlot), 32'd1);
        @(negedge clk);
        set_ctrl(1, 1, 1);
        tick("flush_stall");
        chk("flush_stall.ids_k", 32'(idIsInDelaySlot), 32'd0);
        chk("flush_stall.valid_k", 32'(exValid), 32'd0);

        // Delay-slot propagation.
        @(negedge clk);
        set_ctrl(0, 0, 0);
        idInDelaySlot = 1'b0; idNextInDelaySlot = 1'b1;
        tick("ds_branch");
        chk("ds_branch.ids_k", 32'(idIsInDelaySlot), 32'd1);
        @(negedge clk);
        idInDelaySlot = 1'b1; idNextInDelaySlot = 1'b0;
        tick("ds_slot");
        chk("ds_slot.exds_k", 32'(exInDelaySlot), 32'd1);
        chk("ds_slot.ids_k", 32'(idIsInDelaySlot), 32'd0);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 150) begin
                set_ctrl(0, 1, 1);
                #3;
                rst = 1'b0;
                #1;
                m = '0;
                m_ids = 1'b0;
                check_all("async_reset");
                tick("in_reset");
                @(negedge clk);
                rst = 1'b1;
            end
            randomize_id();
            case ($urandom_range(0, 3))
                0, 1:    set_ctrl(($urandom_range(0, 9) == 0), 0, 0);
                2:       set_ctrl(($urandom_range(0, 9) == 0), 1, 0);
                default: set_ctrl(($urandom_range(0, 9) == 0), 1, 1);
            endcase
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
